// File: rtl/edge_detector_pkg.sv
// Shared definitions for the edge detector: synchronizer depth, reset default,
// and the per-bit event encoding handed to consumers.
package edge_detector_pkg;

  // Depth of the optional input synchronizer.
  localparam int unsigned SYNC_STAGES = 2;

  // Default per-bit level treated as "prior" after reset.
  localparam logic RESET_VAL_DEFAULT = 1'b0;

  // Per-bit event encoding; rise and fall are mutually exclusive.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Classify one bit given the current and previous samples.
  function automatic edge_t detect_edge(input logic cur, input logic prev);
    edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/edge_sync_2ff.sv
// Per-bit multi-flop synchronizer (SYNC_STAGES deep) with async active-low
// reset. Flops reset to RESET_VAL so no spurious edge appears after reset.
module edge_sync_2ff
  import edge_detector_pkg::*;
#(
  parameter logic RESET_VAL = RESET_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Per-bit rising/falling/any edge detector with registered one-cycle pulses.
// Define EDGE_DETECTOR_SYNC_EN to place a 2-flop synchronizer in front of each
// bit (latency 3 instead of 1, safe for asynchronous inputs).
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_VAL_DEFAULT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] rising_edge,
  output logic [WIDTH-1:0] falling_edge,
  output logic [WIDTH-1:0] any_edge
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;

`ifdef EDGE_DETECTOR_SYNC_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    edge_sync_2ff #(
      .RESET_VAL(RESET_VAL[i])
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (signal[i]),
      .q_o  (sampled[i])
    );
  end
`else
  // Input is assumed synchronous to clk.
  assign sampled = signal;
`endif

  // Compare each bit's new sample against the previous one.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {rise_d[i], fall_d[i]} = detect_edge(sampled[i], prev_q[i]);
    end
  end

  // Previous-sample and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= sampled;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;
  assign any_edge     = rise_q | fall_q;

endmodule

// File: tb/tb_edge_detector.sv
module tb_edge_detector;

  localparam int unsigned W   = 4;
  localparam logic [W-1:0] RV0 = 4'b0000;
  localparam logic [W-1:0] RV1 = 4'b0110;
`ifdef EDGE_DETECTOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sig;
  logic [W-1:0] rise0, fall0, any0;
  logic [W-1:0] rise1, fall1, any1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_detector #(.WIDTH(W), .RESET_VAL(RV0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal      (sig),
    .rising_edge (rise0),
    .falling_edge(fall0),
    .any_edge    (any0)
  );

  edge_detector #(.WIDTH(W), .RESET_VAL(RV1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal      (sig),
    .rising_edge (rise1),
    .falling_edge(fall1),
    .any_edge    (any1)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: history of samples seen at each posedge since reset, prefilled
  // with the reset level. The detector effectively compares the sample taken
  // LAT-1 edges ago against the one before it.
  logic [W-1:0] h0[$];
  logic [W-1:0] h1[$];

  always @(posedge clk) begin
    logic [W-1:0] er0, ef0, er1, ef1;
    int n;
    if (!rst_n) begin
      h0 = {};
      h1 = {};
      for (int k = 0; k < LAT; k++) begin
        h0.push_back(RV0);
        h1.push_back(RV1);
      end
    end else begin
      h0.push_back(sig);
      h1.push_back(sig);
      while (h0.size() > LAT + 1) void'(h0.pop_front());
      while (h1.size() > LAT + 1) void'(h1.pop_front());
    end
    #1;
    er0 = '0; ef0 = '0; er1 = '0; ef1 = '0;
    n = h0.size();
    if (rst_n && n == LAT + 1) begin
      er0 = h0[1] & ~h0[0];
      ef0 = ~h0[1] & h0[0];
      er1 = h1[1] & ~h1[0];
      ef1 = ~h1[1] & h1[0];
    end
    check("m_rise0", rise0, er0);
    check("m_fall0", fall0, ef0);
    check("m_any0", any0, er0 | ef0);
    check("m_rise1", rise1, er1);
    check("m_fall1", fall1, ef1);
    check("m_any1", any1, er1 | ef1);
    check("excl0", rise0 & fall0, '0);
    check("excl1", rise1 & fall1, '0);
  end

  // Drive a value, hold it, and check the pulse once it emerges.
  task automatic step(input logic [W-1:0] v, input logic [W-1:0] er, input logic [W-1:0] ef);
    @(negedge clk);
    sig = v;
    repeat (LAT) @(posedge clk);
    #1;
    check("lit_rise", rise0, er);
    check("lit_fall", fall0, ef);
    check("lit_any", any0, er | ef);
  endtask

  initial begin
    logic [W-1:0] cur, nxt;
    rst_n = 1'b0;
    sig   = 4'hF;

    // Reset held with input high: outputs stay low.
    #1;
    check("rst_rise", rise0, '0);
    check("rst_any", any0, '0);
    @(negedge clk);
    check("rst_rise_t10", rise0, '0);
    check("rst_fall1_t10", fall1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("rel_rise0", rise0, 4'hF);
    check("rel_fall0", fall0, 4'h0);
    check("rel_rise1", rise1, 4'b1001);
    check("rel_fall1", fall1, 4'b0000);
    @(posedge clk);
    #1;
    check("rel_once0", rise0, 4'h0);
    check("rel_once1", rise1, 4'h0);

    // Repeated write of the same value, then single-bit pattern.
    step(4'hF, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'hF);
    step(4'h1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 4'h1);
    step(4'h1, 4'h1, 4'h0);
    step(4'h1, 4'h0, 4'h0);

    // Independent multi-bit patterns.
    step(4'b0000, 4'b0000, 4'b0001);
    step(4'b0101, 4'b0101, 4'b0000);
    step(4'b1010, 4'b1010, 4'b0101);

    // Toggle every step.
    cur = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      nxt = ~cur;
      step(nxt, nxt & ~cur, ~nxt & cur);
      cur = nxt;
    end

    // Reset asserted mid-pulse clears outputs immediately.
    step(4'h0, 4'h0, cur);
    step(4'hF, 4'hF, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rise0", rise0, '0);
    check("async_any0", any0, '0);
    check("async_any1", any1, '0);
    sig = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("post_rst_rise0", rise0, 4'h0);
    check("post_rst_fall0", fall0, 4'h0);
    check("post_rst_fall1", fall1, 4'b0110);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_quiet0", any0, 4'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) sig = 4'($urandom);
      rst_n = ($urandom_range(0, 39) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
